unidade_controle: RTL

- Multicycle control FSM that sequences the datapath: fetch, decode, execute, memory, writeback, branch.
- Drives the 4-bit `estado` bus consumed by the decode stage (decoder captures on `estado`=0001) and by the other datapath stages.
- Generates per-state control strobes and handles memory wait-states with a timeout.
- Counts retired instructions.

---
 rtl/unidade_controle.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/unidade_controle.sv
// Multicycle control FSM: fetch/decode/exec/mem/writeback/branch with memory wait timeout.
// Optional single-step pause after each retirement when CTRL_SINGLE_STEP_EN is defined.
module unidade_controle #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             step,
  output logic [3:0]       estado,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WcW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [WcW-1:0] WaitLim = WcW'(WAIT_LIMIT);

  typedef enum logic [3:0] {
    StFetch  = 4'b0000,
    StDecode = 4'b0001,
    StExec   = 4'b0010,
    StMem    = 4'b0011,
    StWb     = 4'b0100,
    StBranch = 4'b0101,
    StPause  = 4'b0110,
    StTrap   = 4'b1111
  } state_e;

`ifdef CTRL_SINGLE_STEP_EN
  localparam state_e StRetire = StPause;
`else
  localparam state_e StRetire = StFetch;
  logic unused_step;
  assign unused_step = step;
`endif

  state_e           state_q, state_d;
  logic [WcW-1:0]   wait_q, wait_d;
  logic             illegal_q, illegal_d;
  logic             bus_error_q, bus_error_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  logic [2:0] op_class;
  logic       is_load, is_store, is_r, is_branch, op_legal;
  logic       br_valid, taken, timeout;
  logic       unused_opcode_bits;

  assign op_class  = opcode[6:4];
  assign is_load   = (op_class == 3'b000);
  assign is_store  = (op_class == 3'b010);
  assign is_r      = (op_class == 3'b011);
  assign is_branch = (op_class == 3'b110);
  assign op_legal  = (opcode[1:0] == 2'b11) &&
                     (is_load || is_store || is_r || is_branch || (op_class == 3'b001));
  assign unused_opcode_bits = ^opcode[3:2];

  assign br_valid = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign taken    = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
  // A zero limit disables the timeout entirely.
  assign timeout  = (WAIT_LIMIT != 0) && (wait_q == WaitLim);

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    retire      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    alu_src     = 1'b0;
    mem_to_reg  = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        if (mem_ready) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d     = StTrap;
          bus_error_d = 1'b1;
        end
      end
      StDecode: begin
        if (!op_legal) begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end else if (is_branch) begin
          state_d = StBranch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        alu_src = !is_r;
        state_d = (is_load || is_store) ? StMem : StWb;
      end
      StMem: begin
        mem_read  = is_load;
        mem_write = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = StRetire;
          end else begin
            state_d = StWb;
          end
        end else if (timeout) begin
          state_d     = StTrap;
          bus_error_d = 1'b1;
        end
      end
      StWb: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_d    = StRetire;
      end
      StBranch: begin
        if (br_valid) begin
          pc_write = 1'b1;
          pc_src   = taken;
          retire   = 1'b1;
          state_d  = StRetire;
        end else begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end
      end
      StPause: begin
`ifdef CTRL_SINGLE_STEP_EN
        if (step) state_d = StFetch;
`else
        state_d = StFetch;
`endif
      end
      StTrap: state_d = StTrap;
      default: state_d = StFetch;
    endcase

    // Reset aborts the current access without any strobe reaching the datapath.
    if (reset) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == StFetch || state_q == StMem) && (WAIT_LIMIT != 0)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFetch;
      wait_q      <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  assign estado    = state_q;
  assign illegal   = illegal_q;
  assign bus_error = bus_error_q;
  assign retired   = retired_q;

endmodule
